// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU front-end types and constants
// Purpose: instruction width, default address width, reset PC and the
//          fetch-entry record carried from the ROM to the decoder.
package cpu_pkg;

    localparam int INSTR_W  = 32;
    localparam int ADDR_W   = 8;
    localparam int RESET_PC = 0;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch queue between instruction ROM and decoder
// Purpose: DEPTH-entry circular FIFO with flush; head is presented
//          combinationally and reads as zero when the queue is empty.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           drop every entry (dominates push/pop)
//   push, push_data write one entry at the tail
//   pop             retire the head entry (ignored when empty)
//   head            current head entry, zero when empty
//   empty           no entries held
//   count           number of entries held
module fetch_fifo #(
    parameter int   WIDTH = 40,
    parameter int   DEPTH = 2,
    localparam int  PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int  CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: contents are only observed through count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC, ROM read sequencing and decoder handshake
// Purpose: issues reads to a 1-cycle-latency instruction ROM, queues the
//          returned words with their PCs and hands them to the decoder.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   imem_en, imem_addr      ROM read request
//   imem_rdata              ROM data, one cycle after imem_en
//   halt                    stop issuing new reads
//   redirect, redirect_pc   flush and restart fetch at redirect_pc
//   instr_valid/instr_ready decoder handshake
//   instr_out, instr_pc     head instruction and the address it came from
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int DEPTH    = 2,
    parameter int RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               halt,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc
);

    localparam int CW      = $clog2(DEPTH + 1);
    localparam int OW      = CW + 1;
    localparam int ENTRY_W = INSTR_W + ADDR_W;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic              squash;
    logic              push;
    logic              pop;
    logic              issue;
    logic [CW-1:0]     count;
    logic [OW-1:0]     occupancy;
    logic              fifo_empty;
    entry_t            push_entry;
    entry_t            head_entry;
    logic [ENTRY_W-1:0] head_raw;

    // A redirect never coincides with an issue, so a read can only be in
    // flight across at most one redirect cycle: squashing the response in
    // that cycle is enough to keep stale words out of the queue.
    assign squash = redirect;
    assign push   = inflight && !squash;

    assign instr_valid = !fifo_empty && !redirect;
    assign pop         = instr_valid && instr_ready;

    // Entries committed for the next cycle: queue after this pop plus the
    // word landing this cycle. A new read must leave room for its response.
    assign occupancy = OW'(count) - OW'(pop) + OW'(inflight);
    assign issue     = !halt && !redirect && (occupancy < OW'(DEPTH));

    assign imem_en   = issue && rst_n;
    assign imem_addr = pc;

    assign push_entry.instr = imem_rdata;
    assign push_entry.pc    = inflight_pc;

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head_raw),
        .empty     (fifo_empty),
        .count     (count)
    );

    assign head_entry = entry_t'(head_raw);
    assign instr_out  = head_entry.instr;
    assign instr_pc   = head_entry.pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= ADDR_W'(RESET_PC);
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
            end
            if (redirect) begin
                pc <= redirect_pc;
            end else if (issue) begin
                pc <= pc + 1'b1;
            end
        end
    end

endmodule
